// File: rtl/csr_trap_unit.sv
`default_nettype none
// ======================================================================
// csr_trap_unit : machine/supervisor CSR file with trap entry/return FSM
// Rev 1.0
// ======================================================================
module csr_trap_unit #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] RESET_MTVEC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            csrunitin_valid,
   input  logic [31:0]     csrunitin_inst,
   input  logic            csrunitin_csr_write,
   input  logic            csrunitin_is_mret,
   input  logic            csrunitin_is_sret,
   input  logic [XLEN-1:0] csrunitin_pc,
   input  logic [XLEN-1:0] csrunitin_rs1_data,
   output logic [XLEN-1:0] csrunitout_rdata,
   output logic            csrunitout_stall,
   output logic            csrunitout_redirect,
   output logic [XLEN-1:0] csrunitout_redirect_pc,
   output logic [1:0]      csrunitout_priv,
   output logic [XLEN-1:0] csrunitout_satp
);

   localparam logic [11:0] ADDR_SSTATUS = 12'h100;
   localparam logic [11:0] ADDR_STVEC   = 12'h105;
   localparam logic [11:0] ADDR_SEPC    = 12'h141;
   localparam logic [11:0] ADDR_SCAUSE  = 12'h142;
   localparam logic [11:0] ADDR_SATP    = 12'h180;
   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MTVEC   = 12'h305;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   localparam logic [31:0] INST_ECALL = 32'h0000_0073;
   localparam logic [31:0] INST_UNIMP = 32'hc000_1073;

   localparam int BIT_SIE  = 1;
   localparam int BIT_MIE  = 3;
   localparam int BIT_SPIE = 5;
   localparam int BIT_MPIE = 7;
   localparam int BIT_SPP  = 8;
   localparam int BIT_MPP0 = 11;
   localparam int BIT_MPP1 = 12;

   localparam logic [XLEN-1:0] SSTATUS_MASK = {{(XLEN-12){1'b0}}, 12'h122};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_EXEC     = 2'd1,
      ST_REDIRECT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      EV_NONE = 2'd0,
      EV_TRAP = 2'd1,
      EV_MRET = 2'd2,
      EV_SRET = 2'd3
   } event_t;

   state_t          state;
   event_t          ev_kind;
   logic [XLEN-1:0] ev_pc;
   logic [3:0]      ev_cause;

   logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
   logic [XLEN-1:0] stvec, sepc, scause, satp;
   logic [1:0]      priv;
   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   logic [11:0]     csr_addr;
   logic [2:0]      funct3;
   logic [4:0]      zimm;
   logic            is_ecall, is_unimp;
   logic            ev_trap, ev_ret, accept;
   logic            csr_op, csr_we;
   logic [XLEN-1:0] rdata, src, new_val, new_val_al;
   logic [XLEN-1:0] mstatus_trap, mstatus_mret, mstatus_sret;

   assign csr_addr = csrunitin_inst[31:20];
   assign funct3   = csrunitin_inst[14:12];
   assign zimm     = csrunitin_inst[19:15];

   assign is_ecall = (csrunitin_inst == INST_ECALL);
   assign is_unimp = (csrunitin_inst == INST_UNIMP);
   assign ev_trap  = csrunitin_valid & csrunitin_csr_write & (is_ecall | is_unimp);
   assign ev_ret   = csrunitin_valid & (csrunitin_is_mret | csrunitin_is_sret);
   assign accept   = (state == ST_IDLE) & (ev_trap | ev_ret);

   // unimp encodes as a csrrw; trap/return decoding takes priority over the CSR access
   assign csr_op = (state == ST_IDLE) & csrunitin_valid & csrunitin_csr_write
                 & ~ev_trap & ~ev_ret & (funct3[1:0] != 2'b00);
   assign csr_we = csr_op & ((funct3[1:0] == 2'b01) | (zimm != 5'd0));

   always_comb begin
      rdata = '0;
      case (csr_addr)
         ADDR_MSTATUS: rdata = mstatus;
         ADDR_SSTATUS: rdata = mstatus & SSTATUS_MASK;
         ADDR_MTVEC:   rdata = mtvec;
         ADDR_MEPC:    rdata = mepc;
         ADDR_MCAUSE:  rdata = mcause;
         ADDR_STVEC:   rdata = stvec;
         ADDR_SEPC:    rdata = sepc;
         ADDR_SCAUSE:  rdata = scause;
         ADDR_SATP:    rdata = satp;
         default:      rdata = '0;
      endcase
   end

   always_comb begin
      src = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : csrunitin_rs1_data;
      case (funct3[1:0])
         2'b01:   new_val = src;
         2'b10:   new_val = rdata | src;
         default: new_val = rdata & ~src;
      endcase
      new_val_al = {new_val[XLEN-1:2], 2'b00};
   end

   always_comb begin
      mstatus_trap                        = mstatus;
      mstatus_trap[BIT_MPIE]              = mstatus[BIT_MIE];
      mstatus_trap[BIT_MIE]               = 1'b0;
      mstatus_trap[BIT_MPP1:BIT_MPP0]     = priv;

      mstatus_mret                        = mstatus;
      mstatus_mret[BIT_MIE]               = mstatus[BIT_MPIE];
      mstatus_mret[BIT_MPIE]              = 1'b1;
      mstatus_mret[BIT_MPP1:BIT_MPP0]     = 2'b00;

      mstatus_sret                        = mstatus;
      mstatus_sret[BIT_SIE]               = mstatus[BIT_SPIE];
      mstatus_sret[BIT_SPIE]              = 1'b1;
      mstatus_sret[BIT_SPP]               = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         ev_kind     <= EV_NONE;
         ev_pc       <= '0;
         ev_cause    <= 4'd0;
         mstatus     <= '0;
         mtvec       <= RESET_MTVEC;
         mepc        <= '0;
         mcause      <= '0;
         stvec       <= '0;
         sepc        <= '0;
         scause      <= '0;
         satp        <= '0;
         priv        <= 2'd3;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else begin
         redirect    <= 1'b0;
         redirect_pc <= '0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state    <= ST_EXEC;
                  ev_pc    <= csrunitin_pc;
                  ev_kind  <= ev_trap ? EV_TRAP : (csrunitin_is_mret ? EV_MRET : EV_SRET);
                  // ecall cause is 8 + privilege (8, 9, 11); unimp is illegal instruction
                  ev_cause <= is_ecall ? {2'b10, priv} : 4'd2;
               end else if (csr_we) begin
                  case (csr_addr)
                     ADDR_MSTATUS: mstatus <= new_val;
                     ADDR_SSTATUS: mstatus <= (mstatus & ~SSTATUS_MASK) | (new_val & SSTATUS_MASK);
                     ADDR_MTVEC:   mtvec   <= new_val_al;
                     ADDR_MEPC:    mepc    <= new_val_al;
                     ADDR_MCAUSE:  mcause  <= new_val;
                     ADDR_STVEC:   stvec   <= new_val_al;
                     ADDR_SEPC:    sepc    <= new_val_al;
                     ADDR_SCAUSE:  scause  <= new_val;
                     ADDR_SATP:    satp    <= new_val;
                     default: ;
                  endcase
               end
            end
            ST_EXEC: begin
               state    <= ST_REDIRECT;
               redirect <= 1'b1;
               case (ev_kind)
                  EV_TRAP: begin
                     mepc        <= ev_pc;
                     mcause      <= {{(XLEN-4){1'b0}}, ev_cause};
                     mstatus     <= mstatus_trap;
                     priv        <= 2'd3;
                     redirect_pc <= mtvec;
                  end
                  EV_MRET: begin
                     mstatus     <= mstatus_mret;
                     priv        <= mstatus[BIT_MPP1:BIT_MPP0];
                     redirect_pc <= mepc;
                  end
                  EV_SRET: begin
                     mstatus     <= mstatus_sret;
                     priv        <= {1'b0, mstatus[BIT_SPP]};
                     redirect_pc <= sepc;
                  end
                  default: ;
               endcase
            end
            ST_REDIRECT: state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

   assign csrunitout_rdata       = rdata;
   assign csrunitout_stall       = accept | (state == ST_EXEC);
   assign csrunitout_redirect    = redirect;
   assign csrunitout_redirect_pc = redirect_pc;
   assign csrunitout_priv        = priv;
   assign csrunitout_satp        = satp;

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_unit.sv
`default_nettype none
// ======================================================================
// tb_csr_trap_unit : directed + randomized bench against a CSR/trap model
// Rev 1.0
// ======================================================================
module tb_csr_trap_unit;

   localparam logic [63:0] RST_MTVEC = 64'h0000_0000_0000_0400;
   localparam logic [63:0] SMASK     = 64'h122;
   localparam logic [31:0] ECALL     = 32'h0000_0073;
   localparam logic [31:0] UNIMP     = 32'hc000_1073;

   logic        clk, rst, valid, csr_write, is_mret, is_sret;
   logic [31:0] inst;
   logic [63:0] pc, rs1_data, rdata, redirect_pc, satp;
   logic        stall, redirect;
   logic [1:0]  priv;

   int errors = 0;
   int checks = 0;

   csr_trap_unit #(.XLEN(64), .RESET_MTVEC(RST_MTVEC)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .csrunitin_valid        (valid),
      .csrunitin_inst         (inst),
      .csrunitin_csr_write    (csr_write),
      .csrunitin_is_mret      (is_mret),
      .csrunitin_is_sret      (is_sret),
      .csrunitin_pc           (pc),
      .csrunitin_rs1_data     (rs1_data),
      .csrunitout_rdata       (rdata),
      .csrunitout_stall       (stall),
      .csrunitout_redirect    (redirect),
      .csrunitout_redirect_pc (redirect_pc),
      .csrunitout_priv        (priv),
      .csrunitout_satp        (satp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // architectural reference state
   logic [63:0] m_mstatus, m_mtvec, m_mepc, m_mcause, m_stvec, m_sepc, m_scause, m_satp;
   logic [1:0]  m_priv;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      m_mstatus = 0; m_mtvec = RST_MTVEC; m_mepc = 0; m_mcause = 0;
      m_stvec = 0; m_sepc = 0; m_scause = 0; m_satp = 0; m_priv = 2'd3;
   endfunction

   function automatic logic [63:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return m_mstatus;
         12'h100: return m_mstatus & SMASK;
         12'h305: return m_mtvec;
         12'h341: return m_mepc;
         12'h342: return m_mcause;
         12'h105: return m_stvec;
         12'h141: return m_sepc;
         12'h142: return m_scause;
         12'h180: return m_satp;
         default: return 64'd0;
      endcase
   endfunction

   function automatic void m_write(input logic [11:0] a, input logic [63:0] v);
      case (a)
         12'h300: m_mstatus = v;
         12'h100: m_mstatus = (m_mstatus & ~SMASK) | (v & SMASK);
         12'h305: m_mtvec   = v & ~64'h3;
         12'h341: m_mepc    = v & ~64'h3;
         12'h342: m_mcause  = v;
         12'h105: m_stvec   = v & ~64'h3;
         12'h141: m_sepc    = v & ~64'h3;
         12'h142: m_scause  = v;
         12'h180: m_satp    = v;
         default: ;
      endcase
   endfunction

   task automatic idle_inputs();
      valid = 0; csr_write = 0; is_mret = 0; is_sret = 0; inst = 32'h0000_0013;
   endtask

   task automatic do_reset();
      rst = 1; idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst = 0;
      m_reset();
      #1;
      check("rst_stall", stall, 0);
      check("rst_redirect", redirect, 0);
      check("rst_redirect_pc", redirect_pc, 0);
      check("rst_priv", priv, 3);
      check("rst_satp", satp, 0);
   endtask

   task automatic csr_op(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] r1,
                         input logic [63:0] v, output logic [63:0] obs);
      logic [63:0] old, src, nv;
      valid = 1; csr_write = 1; is_mret = 0; is_sret = 0;
      inst = {a, r1, f3, 5'd1, 7'h73}; rs1_data = v; pc = {$urandom, $urandom};
      #1;
      old = m_read(a);
      obs = rdata;
      check("csr_rdata", rdata, old);
      check("csr_stall", stall, 0);
      check("csr_priv", priv, m_priv);
      check("csr_satp", satp, m_satp);
      src = f3[2] ? {59'd0, r1} : v;
      case (f3[1:0])
         2'b01:   nv = src;
         2'b10:   nv = old | src;
         default: nv = old & ~src;
      endcase
      if (f3[1:0] == 2'b01 || r1 != 5'd0) m_write(a, nv);
      @(posedge clk); #1 idle_inputs();
   endtask

   task automatic rd(input logic [11:0] a, output logic [63:0] obs);
      csr_op(a, 3'b010, 5'd0, {$urandom, $urandom}, obs);
   endtask

   // kind: 0 ecall, 1 unimp, 2 mret, 3 sret; inputs stay held through the sequence
   task automatic do_event(input int kind, input logic [63:0] epc, output logic [63:0] obs_pc);
      logic [63:0] tgt;
      logic [1:0]  old_priv;
      valid = 1; pc = epc; rs1_data = {$urandom, $urandom};
      csr_write = (kind < 2); is_mret = (kind == 2); is_sret = (kind == 3);
      inst = (kind == 0) ? ECALL : (kind == 1) ? UNIMP : (kind == 2) ? 32'h3020_0073 : 32'h1020_0073;
      old_priv = m_priv;
      #1;
      check("ev_stall_n0", stall, 1);
      check("ev_redirect_n0", redirect, 0);
      tgt = 0;
      case (kind)
         0, 1: begin
            m_mcause = (kind == 0) ? 64'd8 + {62'd0, m_priv} : 64'd2;
            m_mepc = epc;
            m_mstatus[7] = m_mstatus[3];
            m_mstatus[3] = 1'b0;
            m_mstatus[12:11] = m_priv;
            m_priv = 2'd3;
            tgt = m_mtvec;
         end
         2: begin
            tgt = m_mepc;
            m_mstatus[3] = m_mstatus[7];
            m_mstatus[7] = 1'b1;
            m_priv = m_mstatus[12:11];
            m_mstatus[12:11] = 2'b00;
         end
         default: begin
            tgt = m_sepc;
            m_mstatus[1] = m_mstatus[5];
            m_mstatus[5] = 1'b1;
            m_priv = {1'b0, m_mstatus[8]};
            m_mstatus[8] = 1'b0;
         end
      endcase
      @(posedge clk); #1;
      check("ev_stall_n1", stall, 1);
      check("ev_redirect_n1", redirect, 0);
      check("ev_priv_n1", priv, old_priv);
      @(posedge clk); #1;
      check("ev_redirect_n2", redirect, 1);
      check("ev_redirect_pc", redirect_pc, tgt);
      check("ev_stall_n2", stall, 0);
      check("ev_priv_n2", priv, m_priv);
      obs_pc = redirect_pc;
      idle_inputs();
      @(posedge clk); #1;
      check("ev_redirect_n3", redirect, 0);
      check("ev_redirect_pc_n3", redirect_pc, 0);
   endtask

   logic [63:0] obs;
   logic [11:0] addrs [10] = '{12'h300, 12'h100, 12'h305, 12'h341, 12'h342,
                              12'h105, 12'h141, 12'h142, 12'h180, 12'h7c0};
   logic [2:0]  f3s [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

   initial begin
      rst = 1; idle_inputs(); pc = 0; rs1_data = 0;
      @(posedge clk); #1;
      do_reset();
      rd(12'h305, obs);  check("reset_mtvec", obs, RST_MTVEC);
      rd(12'h300, obs);  check("reset_mstatus", obs, 0);

      // csrrw mtvec: old value returned, low bits forced to zero
      csr_op(12'h305, 3'b001, 5'd5, 64'h8000_0103, obs);
      check("csrrw_mtvec_old", obs, RST_MTVEC);
      rd(12'h305, obs);  check("mtvec_aligned", obs, 64'h8000_0100);

      // ecall from M with MIE set
      csr_op(12'h300, 3'b110, 5'd8, 64'd0, obs);
      do_event(0, 64'h8000_2000, obs);
      check("ecall_target", obs, 64'h8000_0100);
      rd(12'h341, obs);  check("ecall_mepc", obs, 64'h8000_2000);
      rd(12'h342, obs);  check("ecall_mcause", obs, 64'd11);
      rd(12'h300, obs);  check("ecall_mstatus", obs & 64'h1888, 64'h1880);

      // mret to U
      csr_op(12'h300, 3'b011, 5'd5, 64'h1800, obs);
      csr_op(12'h341, 3'b001, 5'd5, 64'h1000, obs);
      do_event(2, 64'h5000, obs);
      check("mret_target", obs, 64'h1000);
      check("mret_priv", priv, 0);
      rd(12'h300, obs);  check("mret_mstatus", obs & 64'h1888, 64'h0088);

      // traps from lower privilege
      do_event(1, 64'h3000, obs);
      rd(12'h342, obs);  check("unimp_mcause", obs, 64'd2);
      check("unimp_priv", priv, 3);
      csr_op(12'h300, 3'b011, 5'd5, 64'h1800, obs);
      csr_op(12'h300, 3'b010, 5'd5, 64'h0800, obs);
      csr_op(12'h341, 3'b001, 5'd5, 64'h4000, obs);
      do_event(2, 64'h3004, obs);
      check("to_s_priv", priv, 1);
      do_event(0, 64'h4000, obs);
      rd(12'h342, obs);  check("ecall_s_mcause", obs, 64'd9);

      // sstatus masking and sret
      do_reset();
      csr_op(12'h100, 3'b001, 5'd5, 64'hffff_ffff_ffff_ffff, obs);
      rd(12'h300, obs);  check("sstatus_mask", obs, 64'h122);
      csr_op(12'h141, 3'b001, 5'd5, 64'h2000, obs);
      do_event(3, 64'h6000, obs);
      check("sret_target", obs, 64'h2000);
      check("sret_priv", priv, 1);

      // reset while in EXEC aborts the trap
      do_reset();
      valid = 1; csr_write = 1; inst = ECALL; pc = 64'h8000_2000;
      #1 check("rexec_stall_n0", stall, 1);
      @(posedge clk); #1;
      rst = 1; idle_inputs();
      @(posedge clk); #1;
      rst = 0; m_reset();
      #1;
      check("rexec_redirect", redirect, 0);
      check("rexec_stall", stall, 0);
      check("rexec_priv", priv, 3);
      @(posedge clk); #1;
      check("rexec_redirect_n3", redirect, 0);
      rd(12'h341, obs);  check("rexec_mepc", obs, 0);

      // randomized mix against the model
      for (int it = 0; it < 300; it++) begin
         int k;
         k = $urandom_range(0, 10);
         if (k <= 5) begin
            csr_op(addrs[$urandom_range(0, 9)], f3s[$urandom_range(0, 5)],
                   5'($urandom_range(0, 31)), {$urandom, $urandom}, obs);
         end else if (k <= 9) begin
            do_event(k - 6, {$urandom, $urandom}, obs);
         end else begin
            // decode flags without valid must not start anything
            valid = 0; csr_write = 1; inst = ECALL; is_mret = 1;
            #1 check("novalid_stall", stall, 0);
            @(posedge clk); #1 idle_inputs();
            check("novalid_redirect", redirect, 0);
         end
      end
      for (int i = 0; i < 10; i++) rd(addrs[i], obs);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/csr_trap_unit.md
# csr_trap_unit

Architectural CSR state and trap sequencer that consumes the MEM-stage CSR decode flags (`csr_write`, `is_mret`, `is_sret`) and executes what they request. It holds mstatus/sstatus, mtvec, mepc, mcause, stvec, sepc, scause and satp, performs csrrw/csrrs/csrrc and immediate variants, and runs multi-cycle trap entry (ecall, unimp) and trap return (mret, sret). It stalls the pipeline and issues a single-cycle PC redirect. It sits beside the MEM stage and drives the fetch redirect mux.

## Interface
- `XLEN`, 64, data and CSR width.
- `RESET_MTVEC`, 64'h0, reset value of mtvec.

- `clk`  in  1  clock. Everything is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `csrunitin_valid`  in  1  MEM-stage instruction valid.
- `csrunitin_inst`  in  32  MEM-stage instruction.
- `csrunitin_csr_write`  in  1  decoder: CSR access, ecall, or unimp permitted.
- `csrunitin_is_mret`  in  1  decoder: mret.
- `csrunitin_is_sret`  in  1  decoder: sret.
- `csrunitin_pc`  in  XLEN  PC of the MEM-stage instruction.
- `csrunitin_rs1_data`  in  XLEN  rs1 operand.
- `csrunitout_rdata`  out  XLEN  old value of CSR `inst[31:20]`. Combinational. 0 for unimplemented addresses.
- `csrunitout_stall`  out  1  freeze the upstream pipeline.
- `csrunitout_redirect`  out  1  one-cycle flush plus PC redirect.
- `csrunitout_redirect_pc`  out  XLEN  redirect target.
- `csrunitout_priv`  out  2  current privilege: 0 = U, 1 = S, 3 = M.
- `csrunitout_satp`  out  XLEN  satp, for the MMU.

## Operation
- **Event classification.** Events are sampled only in IDLE, with `valid` = 1.
  - TRAP: `inst` = 32'h00000073 (ecall) or 32'hc0001073 (unimp), and `csr_write` = 1.
  - RET: `is_mret` or `is_sret`.
  - CSROP: `csr_write` = 1 and funct3 `inst[14:12]` ∈ {001, 010, 011, 101, 110, 111}.
- **FSM states:** IDLE, EXEC, REDIRECT.
  - IDLE → EXEC on TRAP or RET. The event kind, `pc`, and cause are latched on that edge.
  - EXEC → REDIRECT unconditionally. CSR and privilege updates commit on the EXEC → REDIRECT edge.
  - REDIRECT → IDLE unconditionally.
- **CSROP.** Completes in IDLE in a single cycle, with no stall.
  - Source operand: `rs1_data` for funct3 0xx; zero-extended zimm `inst[19:15]` for funct3 1xx.
  - rw: new = src. rs: new = old | src. rc: new = old & ~src.
  - rs and rc with `inst[19:15]` = 0 perform no write.
  - Writes to unimplemented addresses are dropped.
  - mtvec, stvec, mepc and sepc force bits [1:0] to 0 on write.
- **sstatus.** A masked view of mstatus covering SIE[1], SPIE[5] and SPP[8].
  - Reads of sstatus return mstatus with all other bits 0.
  - Writes to sstatus modify only those three bits.
- **TRAP commit.** All traps go to M mode; there is no delegation.
  - mepc ← latched pc.
  - mcause ← 8 + priv for ecall (8, 9 or 11); 2 for unimp.
  - mstatus.MPIE[7] ← MIE[3]; MIE ← 0; MPP[12:11] ← priv.
  - priv ← 3.
  - Redirect target: the new mtvec.
- **mret commit.** MIE ← MPIE; MPIE ← 1; priv ← MPP; MPP ← 0. Redirect target: mepc.
- **sret commit.** SIE ← SPIE; SPIE ← 1; priv ← {0, SPP}; SPP ← 0. Redirect target: sepc.
- **Inputs outside IDLE.** Ignored in EXEC and REDIRECT. The pipeline is stalled and holds the instruction, which must not be re-accepted.
- **Precedence in IDLE.** If TRAP and RET flags are both asserted, TRAP wins.
- **Arithmetic.** All CSRs are XLEN wide. No arithmetic carries.

## Timing
- **Reset values.**
  - All CSRs = 0, except mtvec = `RESET_MTVEC`.
  - priv = 3.
  - FSM = IDLE; latched event state is cleared.
  - `stall` = 0, `redirect` = 0, `redirect_pc` = 0.
- **TRAP/RET sequence.** The event is accepted at cycle N.
  - `stall` = 1 in cycles N and N+1. In cycle N it is combinational from the decode.
  - CSRs and priv show their new values from cycle N+2.
  - `redirect` = 1 in cycle N+2 only, with `redirect_pc` valid in that same cycle.
  - `stall` = 0 in cycle N+2.
  - The next event can be accepted at N+3.
- **CSROP.** `rdata` is valid in the same cycle. The write is visible in the next cycle. Back-to-back CSROPs are supported, and the second one reads the first one's result.
- **`redirect_pc`.** Registered; equals 0 whenever `redirect` = 0.
- **Reset mid-sequence.** Reset in EXEC or REDIRECT: no CSR commit, FSM → IDLE, `redirect` = 0 next cycle.

## Test plan
- **csrrw mtvec.** Reset, then csrrw mtvec with rs1 = 64'h8000_0103 → `rdata` = `RESET_MTVEC` that cycle; the next cycle's mtvec read = 64'h8000_0100.
- **ecall from M.** mtvec = 64'h8000_0100, pc = 64'h8000_2000, MIE = 1, then ecall → `stall` high for 2 cycles, then a 1-cycle `redirect` to 64'h8000_0100. Afterwards mepc = 64'h8000_2000, mcause = 11, MPIE = 1, MIE = 0, MPP = 3.
- **mret to U.** MPP = 0, MPIE = 1, mepc = 64'h1000, then mret → `redirect_pc` = 64'h1000 at N+2; priv = 0, MIE = 1, MPP = 0.
- **Traps from lower privilege.** From U, unimp → mcause = 2, priv = 3. From S, ecall → mcause = 9.
- **sret and sstatus masking.** Write sstatus = all ones → mstatus = 64'h122. Then sret with sepc = 64'h2000 → priv = 1 (SPP = 1), then `redirect` to 64'h2000.
- **Reset in EXEC.** Assert `rst` during EXEC of an ecall → mepc stays 0, no `redirect` pulse, `stall` = 0, priv = 3.
